// File: rtl/lcd_frame_scanner.sv
// lcd_frame_scanner
//   Walks the LCD raster one coordinate at a time. It presents x_pixel/y_pixel
//   to the content generators, samples the returned pixel/active pair, and
//   emits one RGB565 word per coordinate over a valid/ready stream to the
//   LCD write engine.
//
// Parameters
//   H_RES      pixels per line, x counts 0..H_RES-1
//   V_RES      lines per frame, y counts 0..V_RES-1
//   BG_COLOUR  word emitted when no generator claims the coordinate
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   start       frame request, sampled in IDLE only
//   x_pixel     current column presented to generators (registered)
//   y_pixel     current row presented to generators (registered)
//   pixel       RGB565 from generators for the current coordinate
//   active      OR of generator active flags for the current coordinate
//   out_data    pixel word to the LCD writer
//   out_valid   out_data valid
//   out_ready   LCD writer accepts out_data
//   busy        high whenever the scanner is not idle
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
//
// Build option
//   LCD_FRAME_CONTINUOUS_EN  when defined, DONE restarts the next frame
//                            directly if start is high, without passing
//                            through IDLE (one bubble cycle between frames).

module lcd_frame_scanner #(
    parameter int unsigned H_RES     = 320,
    parameter int unsigned V_RES     = 240,
    parameter logic [15:0] BG_COLOUR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [8:0]  x_pixel,
    output logic [7:0]  y_pixel,
    input  logic [15:0] pixel,
    input  logic        active,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done
);

    // Last coordinates at full port width so the comparisons never wrap.
    localparam logic [8:0] X_LAST = 9'(H_RES - 1);
    localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [8:0]  x_nx;
    logic [7:0]  y_nx;
    logic [15:0] data_nx;
    logic        valid_nx;
    logic        handshake;
    logic        last_pixel;

    assign handshake  = out_valid & out_ready;
    assign last_pixel = (x_pixel == X_LAST) && (y_pixel == Y_LAST);

    // State and datapath registers; reset clears any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x_pixel   <= '0;
            y_pixel   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            x_pixel   <= x_nx;
            y_pixel   <= y_nx;
            out_data  <= data_nx;
            out_valid <= valid_nx;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nx = state;
        x_nx     = x_pixel;
        y_nx     = y_pixel;
        data_nx  = out_data;
        valid_nx = out_valid;

        unique case (state)
            IDLE: begin
                if (start) begin
                    x_nx     = '0;
                    y_nx     = '0;
                    state_nx = FETCH;
                end
            end

            // Coordinates were registered last cycle, so the generators'
            // combinational answer is settled here.
            FETCH: begin
                data_nx  = active ? pixel : BG_COLOUR;
                valid_nx = 1'b1;
                state_nx = HOLD;
            end

            HOLD: begin
                if (handshake) begin
                    valid_nx = 1'b0;
                    if (last_pixel) begin
                        state_nx = DONE;
                    end else begin
                        if (x_pixel < X_LAST) begin
                            x_nx = x_pixel + 9'd1;
                        end else begin
                            x_nx = '0;
                            // Guarded so y cannot pass the last line.
                            if (y_pixel < Y_LAST) begin
                                y_nx = y_pixel + 8'd1;
                            end
                        end
                        state_nx = FETCH;
                    end
                end
            end

            DONE: begin
                x_nx = '0;
                y_nx = '0;
`ifdef LCD_FRAME_CONTINUOUS_EN
                state_nx = start ? FETCH : IDLE;
`else
                state_nx = IDLE;
`endif
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Status decoded straight from the state register: both drop to zero
    // in the same cycle reset takes effect.
    always_comb begin
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

endmodule

// File: tb/tb_lcd_frame_scanner.sv
// tb_lcd_frame_scanner
//   Directed bench for lcd_frame_scanner on a 4x2 raster. A small generator
//   model claims only coordinate (1,0) with colour 16'h0000; every other
//   coordinate must come out as the background word 16'hFFFF.

module tb_lcd_frame_scanner;

    localparam int unsigned H    = 4;
    localparam int unsigned V    = 2;
    localparam int unsigned NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  x_pixel;
    logic [7:0]  y_pixel;
    logic [15:0] pixel;
    logic        active;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] w_data[$];
    logic [8:0]  w_x[$];
    logic [7:0]  w_y[$];

    lcd_frame_scanner #(
        .H_RES     (H),
        .V_RES     (V),
        .BG_COLOUR (16'hFFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel),
        .pixel      (pixel),
        .active     (active),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Generator model: only (1,0) is active. Inactive coordinates return a
    // distinct colour so a broken background mux shows up.
    always_comb begin
        active = (x_pixel == 9'd1) && (y_pixel == 8'd0);
        pixel  = active ? 16'h0000 : 16'hA5A5;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_word(input int i);
        return (i == 1) ? 16'h0000 : 16'hFFFF;
    endfunction

    // Runs one frame with out_ready high except for an optional stall at
    // (2,1). Cycle 1 is the FETCH cycle following the edge that samples
    // start. start_word >= 0 pulses start once that many words are taken;
    // rst_word >= 0 applies reset once that many words are taken.
    task automatic run_frame(input int stall_len, input int start_word,
                             input int rst_word, input bit timing);
        int c;
        int first_valid;
        int done_cyc;
        int busy_low;
        int dones;
        int stalled;
        logic [15:0] held;
        w_data.delete();
        w_x.delete();
        w_y.delete();
        first_valid = -1;
        done_cyc    = -1;
        busy_low    = -1;
        dones       = 0;
        stalled     = 0;
        held        = '0;
        out_ready   = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        while (c < 200) begin
            if (rst_word >= 0 && w_data.size() == rst_word) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("midrst_valid", out_valid, 0);
                check("midrst_busy", busy, 0);
                check("midrst_x", x_pixel, 0);
                check("midrst_y", y_pixel, 0);
                check("midrst_done", frame_done, 0);
                return;
            end
            if (first_valid < 0 && out_valid) first_valid = c;
            if (frame_done) begin
                dones++;
                done_cyc = c;
            end
            if (dones > 0 && !busy) begin
                busy_low = c;
                break;
            end
            start = (start_word >= 0 && w_data.size() == start_word && dones == 0);
            if (stalled > 0 && stalled < stall_len) begin
                check("stall_data", out_data, held);
                check("stall_valid", out_valid, 1);
                check("stall_x", x_pixel, 2);
                check("stall_y", y_pixel, 1);
                out_ready = 1'b0;
                stalled++;
            end else if (stalled == 0 && stall_len > 0 && out_valid &&
                         x_pixel == 9'd2 && y_pixel == 8'd1) begin
                held      = out_data;
                out_ready = 1'b0;
                stalled   = 1;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                w_data.push_back(out_data);
                w_x.push_back(x_pixel);
                w_y.push_back(y_pixel);
            end
            tick();
            c++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("frame_end_seen", (busy_low >= 0), 1);
        check("word_count", w_data.size(), NPIX);
        for (int i = 0; i < w_data.size() && i < NPIX; i++) begin
            check($sformatf("word%0d_x", i), w_x[i], i % H);
            check($sformatf("word%0d_y", i), w_y[i], i / H);
            check($sformatf("word%0d_data", i), w_data[i], exp_word(i));
        end
        check("done_pulses", dones, 1);
        if (stall_len > 0) check("stall_cycles", stalled, stall_len);
        if (timing) begin
            check("first_valid_cycle", first_valid, 2);
            check("frame_done_cycle", done_cyc, 17);
            check("busy_low_cycle", busy_low, 18);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_x", x_pixel, 0);
        check("rst_y", y_pixel, 0);
        check("rst_data", out_data, 16'h0000);
        check("rst_done", frame_done, 0);

        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", out_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_x", x_pixel, 0);
            check("idle_y", y_pixel, 0);
            check("idle_done", frame_done, 0);
        end

        // Full frame with colour mux and timing.
        run_frame(0, -1, -1, 1'b1);
        repeat (3) tick();

        // Backpressure at (2,1) for 5 cycles.
        run_frame(5, -1, -1, 1'b0);
        repeat (3) tick();

        // start pulses while busy are ignored; frame timing unchanged.
        run_frame(0, 3, -1, 1'b1);
        repeat (3) tick();

        // Reset after the fifth word.
        run_frame(0, -1, 5, 1'b0);
        tick();

        // rst and start together: reset wins.
        start = 1'b1;
        rst   = 1'b1;
        tick();
        check("rst_start_busy", busy, 0);
        check("rst_start_valid", out_valid, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("rst_start_idle", busy, 0);

        // Fresh frame after the mid-frame reset.
        run_frame(0, -1, -1, 1'b1);

`ifdef LCD_FRAME_CONTINUOUS_EN
        begin
            int c;
            int dones;
            int done_c[2];
            int fv2;
            int bdrop;
            int idle_seen;
            w_data.delete();
            w_x.delete();
            w_y.delete();
            dones     = 0;
            done_c[0] = -1;
            done_c[1] = -1;
            fv2       = -1;
            bdrop     = 0;
            idle_seen = 0;
            out_ready = 1'b1;
            start     = 1'b1;
            tick();
            c = 1;
            while (c < 200 && dones < 2) begin
                if (frame_done) begin
                    done_c[dones] = c;
                    dones++;
                end
                if (dones == 1 && !frame_done && out_valid && fv2 < 0) fv2 = c;
                if (!busy) bdrop++;
                if (out_valid && out_ready) begin
                    w_data.push_back(out_data);
                    w_x.push_back(x_pixel);
                    w_y.push_back(y_pixel);
                end
                if (dones < 2) begin
                    tick();
                    c++;
                end
            end
            start = 1'b0;
            for (int i = 0; i < 50 && !idle_seen; i++) begin
                tick();
                if (!busy) idle_seen = 1;
            end
            check("cont_done_pulses", dones, 2);
            check("cont_word_count", w_data.size(), 2 * NPIX);
            for (int i = 0; i < w_data.size() && i < 2 * NPIX; i++) begin
                check($sformatf("cont%0d_x", i), w_x[i], (i % NPIX) % H);
                check($sformatf("cont%0d_y", i), w_y[i], (i % NPIX) / H);
                check($sformatf("cont%0d_data", i), w_data[i], exp_word(i % NPIX));
            end
            check("cont_busy_drops", bdrop, 0);
            check("cont_frame2_first_valid", fv2, done_c[0] + 2);
            check("cont_frame_period", done_c[1] - done_c[0], 2 * NPIX + 1);
            check("cont_returns_idle", idle_seen, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
